issue_stage: RTL and testbench



---
 rtl/rv32_pkg.sv | 43 ++++
 rtl/issue_scoreboard.sv | 92 +++++++++
 rtl/issue_stage.sv | 128 ++++++++++++
 tb/tb_issue_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : rv32_pkg                                                    |
// | Description: Shared RV32 pipeline types used by the issue stage: the     |
// |              issue packet handed to execute, the writeback packet that   |
// |              also feeds the register file, the pending-write counter     |
// |              type and the "instruction writes rd" helper.                |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package rv32_pkg;

  localparam int XLEN           = 32;
  localparam int REG_SEL_W      = 5;
  localparam int PEND_W_DEFAULT = 2;

  typedef logic [REG_SEL_W-1:0]      rv32_reg_sel_t;
  typedef logic [XLEN-1:0]           rv32_word_t;
  typedef logic [PEND_W_DEFAULT-1:0] rv32_pend_cnt_t;

  typedef struct packed {
    rv32_word_t    pc;
    rv32_reg_sel_t rs1_sel;
    rv32_word_t    rs1_value;
    rv32_reg_sel_t rs2_sel;
    rv32_word_t    rs2_value;
    rv32_reg_sel_t rd_sel;
    rv32_word_t    imm;
  } rv32_issue_packet_t;

  typedef struct packed {
    logic          wb_enable;
    rv32_reg_sel_t wb_addr;
    rv32_word_t    wb_data;
  } rv32_mem2wb_packet_t;

  // The decoder encodes "no destination" (stores, branches) as rd_sel = 0,
  // so x0 doubles as the no-write marker and is never tracked.
  function automatic logic rv32_writes_rd(input rv32_reg_sel_t rd_sel);
    return rd_sel != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : issue_scoreboard                                            |
// | Description: Per-register pending-write counters. A counter goes up when |
// |              an instruction writing that register is dispatched and down |
// |              when its writeback arrives. Reports whether the two source  |
// |              registers still have writes in flight and whether the       |
// |              destination counter would saturate.                         |
// | Macro      : ISSUE_WB_BYPASS_EN - a source whose last pending write     |
// |              retires this cycle is reported as not pending.              |
// | Ports      : clk, resetn        clock, async active-low reset            |
// |              inc_en/inc_addr    dispatch of a write to inc_addr          |
// |              dec_en/dec_addr    writeback to dec_addr                    |
// |              rs1_sel/rs2_sel    sources of the candidate instruction     |
// |              rd_sel/rd_held     its destination; held entry writes rd    |
// |              rs1/rs2_pend_nz    source has a write in flight             |
// |              rd_sat             destination counter is full              |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module issue_scoreboard
  import rv32_pkg::*;
#(
  parameter int PEND_W   = PEND_W_DEFAULT,
  parameter int NUM_REGS = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inc_en,
  input  rv32_reg_sel_t inc_addr,
  input  logic          dec_en,
  input  rv32_reg_sel_t dec_addr,
  input  rv32_reg_sel_t rs1_sel,
  input  rv32_reg_sel_t rs2_sel,
  input  rv32_reg_sel_t rd_sel,
  input  logic          rd_held,
  output logic          rs1_pend_nz,
  output logic          rs2_pend_nz,
  output logic          rd_sat
);

  localparam logic [PEND_W-1:0] c_one      = PEND_W'(1);
  localparam logic [PEND_W:0]   c_pend_max = (PEND_W+1)'((1 << PEND_W) - 1);

  logic [PEND_W-1:0]   r_pend [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [PEND_W:0]     w_rd_total;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign w_inc[g] = inc_en && (inc_addr == REG_SEL_W'(g)) && (g != 0);
    // A writeback with nothing pending is dropped (e.g. in flight across reset).
    assign w_dec[g] = dec_en && (dec_addr == REG_SEL_W'(g)) && (g != 0) &&
                      (r_pend[g] != '0);
  end

  // Simultaneous dispatch and writeback of the same register cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i])      r_pend[i] <= r_pend[i] + c_one;
        else if (!w_inc[i] && w_dec[i]) r_pend[i] <= r_pend[i] - c_one;
      end
    end
  end

`ifdef ISSUE_WB_BYPASS_EN
  // The last pending write retiring this cycle is forwarded by the stage,
  // so the source is treated as available.
  assign rs1_pend_nz = (r_pend[rs1_sel] != '0) &&
                       !(dec_en && (dec_addr == rs1_sel) && (r_pend[rs1_sel] == c_one));
  assign rs2_pend_nz = (r_pend[rs2_sel] != '0) &&
                       !(dec_en && (dec_addr == rs2_sel) && (r_pend[rs2_sel] == c_one));
`else
  assign rs1_pend_nz = r_pend[rs1_sel] != '0;
  assign rs2_pend_nz = r_pend[rs2_sel] != '0;
`endif

  // The held output entry will add one more write to rd once dispatched.
  assign w_rd_total = {1'b0, r_pend[rd_sel]} + {{PEND_W{1'b0}}, rd_held};
  assign rd_sat     = rv32_writes_rd(rd_sel) && (w_rd_total >= c_pend_max);

`ifndef SYNTHESIS
  a_wb_has_pending : assert property (
    @(posedge clk) disable iff (!resetn)
    (dec_en && (dec_addr != '0)) |-> (r_pend[dec_addr] != '0)
  ) else $warning("issue_scoreboard: writeback to register with no pending write ignored");
`endif

endmodule
`default_nettype wire

// File: rtl/issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : issue_stage                                                 |
// | Description: Registered issue stage between register-file read and       |
// |              execute. Holds one packet with valid/ready on both sides    |
// |              and blocks read-after-write hazards with a pending-write    |
// |              scoreboard retired by the writeback packet.                 |
// | Macro      : ISSUE_WB_BYPASS_EN - same-cycle writeback data replaces    |
// |              the captured source value and does not cause a stall.       |
// | Ports      : clk, resetn        clock, async active-low reset            |
// |              in_packet/in_valid/in_ready    upstream handshake           |
// |              writeback_packet               retiring write               |
// |              flush                          kill the held entry          |
// |              out_packet/out_valid/out_ready downstream handshake         |
// |              stall_raw                      in_valid blocked by hazard   |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module issue_stage
  import rv32_pkg::*;
#(
  parameter int PEND_W   = PEND_W_DEFAULT,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  rv32_issue_packet_t  in_packet,
  input  logic                in_valid,
  output logic                in_ready,
  input  rv32_mem2wb_packet_t writeback_packet,
  input  logic                flush,
  output rv32_issue_packet_t  out_packet,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                stall_raw
);

  rv32_issue_packet_t r_out_packet;
  logic               r_out_valid;
  rv32_issue_packet_t w_capture;
  logic               w_xfer_in;
  logic               w_xfer_out;
  logic               w_dispatch;
  logic               w_held_wr;
  logic               w_hmatch_rs1;
  logic               w_hmatch_rs2;
  logic               w_hmatch_rd;
  logic               w_rs1_pend_nz;
  logic               w_rs2_pend_nz;
  logic               w_rd_sat;
  logic               w_src1;
  logic               w_src2;
  logic               w_hazard;

  // The held entry is not yet counted in the scoreboard, so it is matched
  // against the incoming registers directly.
  assign w_held_wr    = r_out_valid && rv32_writes_rd(r_out_packet.rd_sel);
  assign w_hmatch_rs1 = w_held_wr && (r_out_packet.rd_sel == in_packet.rs1_sel);
  assign w_hmatch_rs2 = w_held_wr && (r_out_packet.rd_sel == in_packet.rs2_sel);
  assign w_hmatch_rd  = w_held_wr && (r_out_packet.rd_sel == in_packet.rd_sel);

  // Both sources are checked regardless of format; I-type false stalls are accepted.
  assign w_src1   = (in_packet.rs1_sel != '0) && (w_rs1_pend_nz || w_hmatch_rs1);
  assign w_src2   = (in_packet.rs2_sel != '0) && (w_rs2_pend_nz || w_hmatch_rs2);
  assign w_hazard = w_src1 || w_src2;

  assign in_ready   = (!r_out_valid || out_ready) && !flush && !w_hazard && !w_rd_sat;
  assign stall_raw  = in_valid && w_hazard;
  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = r_out_valid && out_ready;
  // A flushed entry never reaches execute and so is never counted.
  assign w_dispatch = w_xfer_out && !flush;

`ifdef ISSUE_WB_BYPASS_EN
  // The register file writes on the clock edge, so a value written this
  // cycle is not yet visible on its read port; take it from writeback.
  always_comb begin
    w_capture = in_packet;
    if (writeback_packet.wb_enable && (in_packet.rs1_sel != '0) &&
        (writeback_packet.wb_addr == in_packet.rs1_sel))
      w_capture.rs1_value = writeback_packet.wb_data;
    if (writeback_packet.wb_enable && (in_packet.rs2_sel != '0) &&
        (writeback_packet.wb_addr == in_packet.rs2_sel))
      w_capture.rs2_value = writeback_packet.wb_data;
  end
`else
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^writeback_packet.wb_data;
  assign w_capture        = in_packet;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_out_packet <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_xfer_in) begin
      r_out_valid  <= 1'b1;
      r_out_packet <= w_capture;
    end else if (w_xfer_out) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_packet = r_out_packet;

  issue_scoreboard #(
    .PEND_W   (PEND_W),
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk         (clk),
    .resetn      (resetn),
    .inc_en      (w_dispatch && rv32_writes_rd(r_out_packet.rd_sel)),
    .inc_addr    (r_out_packet.rd_sel),
    .dec_en      (writeback_packet.wb_enable),
    .dec_addr    (writeback_packet.wb_addr),
    .rs1_sel     (in_packet.rs1_sel),
    .rs2_sel     (in_packet.rs2_sel),
    .rd_sel      (in_packet.rd_sel),
    .rd_held     (w_hmatch_rd),
    .rs1_pend_nz (w_rs1_pend_nz),
    .rs2_pend_nz (w_rs2_pend_nz),
    .rd_sat      (w_rd_sat)
  );

endmodule
`default_nettype wire

// File: tb/tb_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_issue_stage                                              |
// | Description: Directed self-checking bench for issue_stage. Accepted      |
// |              packets are queued as expected outputs and compared when    |
// |              execute takes them; handshake and counter state are checked |
// |              at every step.                                              |
// | Macro      : ISSUE_WB_BYPASS_EN - selects the matching RAW expectation  |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_issue_stage;
  import rv32_pkg::*;

  logic                clk;
  logic                resetn;
  rv32_issue_packet_t  in_packet;
  logic                in_valid;
  logic                in_ready;
  rv32_mem2wb_packet_t wb;
  logic                flush;
  rv32_issue_packet_t  out_packet;
  logic                out_valid;
  logic                out_ready;
  logic                stall_raw;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  rv32_issue_packet_t exp_q[$];
  rv32_issue_packet_t e_pkt;

  issue_stage #(.PEND_W(2), .NUM_REGS(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_packet        (in_packet),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .writeback_packet (wb),
    .flush            (flush),
    .out_packet       (out_packet),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .stall_raw        (stall_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rv32_issue_packet_t mkpkt(input logic [31:0] pc, input logic [4:0] rs1,
                                               input logic [31:0] rs1v, input logic [4:0] rs2,
                                               input logic [31:0] rs2v, input logic [4:0] rd);
    rv32_issue_packet_t p;
    p = '0;
    p.pc = pc; p.rs1_sel = rs1; p.rs1_value = rs1v;
    p.rs2_sel = rs2; p.rs2_value = rs2v; p.rd_sel = rd;
    return p;
  endfunction

  task automatic idle_in();
    in_valid  = 1'b0;
    in_packet = '0;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb.wb_enable = en;
    wb.wb_addr   = addr;
    wb.wb_data   = data;
  endtask

  // Called at posedge+1 with inputs already driven; checks the settled
  // combinational outputs, maintains the expectation queue, and advances
  // to the next posedge+1.
  task automatic cycle(input logic exp_rdy, input logic exp_ov, input logic exp_stall);
    rv32_issue_packet_t p;
    #1;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_ov);
    chk("stall_raw", stall_raw, exp_stall);
    if (exp_ov && (out_ready || flush)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        n_fail++;
        $error("FAIL sb_underflow: observed empty queue expected entry");
      end else begin
        p = exp_q.pop_front();
        if (!flush) chk("out_packet", out_packet, p);
      end
    end
    if (in_valid && exp_rdy) begin
      p = in_packet;
`ifdef ISSUE_WB_BYPASS_EN
      if (wb.wb_enable && p.rs1_sel != 0 && wb.wb_addr == p.rs1_sel) p.rs1_value = wb.wb_data;
      if (wb.wb_enable && p.rs2_sel != 0 && wb.wb_addr == p.rs2_sel) p.rs2_value = wb.wb_data;
`endif
      exp_q.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle_in();
    set_wb(1'b0, 5'd0, 32'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_packet", out_packet, '0);
    chk("rst_pend3", dut.u_sb.r_pend[3], 2'd0);
    resetn = 1'b1;

    // No hazard: back-to-back accepts
    in_valid  = 1'b1;
    in_packet = mkpkt(32'h10, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd3);
    cycle(1'b1, 1'b0, 1'b0);
    in_packet = mkpkt(32'h14, 5'd4, 32'hA4, 5'd0, 32'h0, 5'd5);
    cycle(1'b1, 1'b1, 1'b0);
    idle_in();
    cycle(1'b1, 1'b1, 1'b0);
    chk("pend3_after_dispatch", dut.u_sb.r_pend[3], 2'd1);
    chk("pend5_after_dispatch", dut.u_sb.r_pend[5], 2'd1);

    // RAW on x3
    in_valid  = 1'b1;
    in_packet = mkpkt(32'h20, 5'd3, 32'h11111111, 5'd0, 32'h0, 5'd6);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
`ifdef ISSUE_WB_BYPASS_EN
    set_wb(1'b1, 5'd3, 32'h1234);
    cycle(1'b1, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    idle_in();
`else
    set_wb(1'b1, 5'd3, 32'hDEADBEEF);
    cycle(1'b0, 1'b0, 1'b1);
    set_wb(1'b0, 5'd0, 32'd0);
    in_packet.rs1_value = 32'hDEADBEEF;
    cycle(1'b1, 1'b0, 1'b0);
    idle_in();
`endif
    cycle(1'b1, 1'b1, 1'b0);
    chk("pend3_retired", dut.u_sb.r_pend[3], 2'd0);
    chk("pend6_after_dispatch", dut.u_sb.r_pend[6], 2'd1);
    set_wb(1'b1, 5'd5, 32'h5);
    cycle(1'b1, 1'b0, 1'b0);
    set_wb(1'b1, 5'd6, 32'h6);
    cycle(1'b1, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    chk("pend5_retired", dut.u_sb.r_pend[5], 2'd0);
    chk("pend6_retired", dut.u_sb.r_pend[6], 2'd0);

    // Saturation / WAW on x7 (PEND_MAX = 3)
    in_valid  = 1'b1;
    in_packet = mkpkt(32'h30, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7);
    cycle(1'b1, 1'b0, 1'b0);
    in_packet = mkpkt(32'h34, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7);
    cycle(1'b1, 1'b1, 1'b0);
    in_packet = mkpkt(32'h38, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7);
    cycle(1'b1, 1'b1, 1'b0);
    in_packet = mkpkt(32'h3C, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("pend7_full", dut.u_sb.r_pend[7], 2'd3);
    set_wb(1'b1, 5'd7, 32'h7);
    cycle(1'b0, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    chk("pend7_after_wb", dut.u_sb.r_pend[7], 2'd2);
    cycle(1'b1, 1'b0, 1'b0);
    idle_in();
    set_wb(1'b1, 5'd7, 32'h7);
    cycle(1'b1, 1'b1, 1'b0);
    chk("pend7_inc_dec_same_cycle", dut.u_sb.r_pend[7], 2'd2);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    chk("pend7_drained", dut.u_sb.r_pend[7], 2'd0);

    // Backpressure then flush
    in_valid  = 1'b1;
    e_pkt     = mkpkt(32'h100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8);
    in_packet = e_pkt;
    cycle(1'b1, 1'b0, 1'b0);
    idle_in();
    out_ready = 1'b0;
    repeat (3) begin
      chk("held_packet", out_packet, e_pkt);
      cycle(1'b0, 1'b1, 1'b0);
    end
    flush = 1'b1;
    cycle(1'b0, 1'b1, 1'b0);
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_pend8", dut.u_sb.r_pend[8], 2'd0);

    // Reset while holding an entry with a write in flight
    in_valid  = 1'b1;
    in_packet = mkpkt(32'h200, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10);
    cycle(1'b1, 1'b0, 1'b0);
    in_packet = mkpkt(32'h204, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9);
    cycle(1'b1, 1'b1, 1'b0);
    idle_in();
    out_ready = 1'b0;
    chk("pre_rst_pend10", dut.u_sb.r_pend[10], 2'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_out_packet", out_packet, '0);
    chk("async_rst_pend10", dut.u_sb.r_pend[10], 2'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_packet = mkpkt(32'h300, 5'd10, 32'hABCD, 5'd0, 32'h0, 5'd11);
    cycle(1'b1, 1'b0, 1'b0);
    idle_in();
    cycle(1'b1, 1'b1, 1'b0);
    set_wb(1'b1, 5'd11, 32'hB);
    cycle(1'b1, 1'b0, 1'b0);
    set_wb(1'b0, 5'd0, 32'd0);
    chk("pend11_drained", dut.u_sb.r_pend[11], 2'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
